// File: rtl/cmd_issue_ctrl_if.sv
// Bundles the host register port and the CMD-block handshake of cmd_issue_ctrl.
// The master side is the host/CMD environment; the slave side is the controller.
interface cmd_issue_ctrl_if;
   logic        reg_wr_en;
   logic [2:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;
   logic        new_cmd;
   logic [31:0] cmd_arg;
   logic [5:0]  cmd_index;
   logic        cmd_busy;
   logic        cmd_complete;
   logic        timeout_error;
   logic [31:0] response_status;
   logic        interrupt;

   modport master (
      output reg_wr_en, reg_addr, reg_wdata, cmd_busy, cmd_complete, timeout_error,
             response_status,
      input  reg_rdata, new_cmd, cmd_arg, cmd_index, interrupt
   );

   modport slave (
      input  reg_wr_en, reg_addr, reg_wdata, cmd_busy, cmd_complete, timeout_error,
             response_status,
      output reg_rdata, new_cmd, cmd_arg, cmd_index, interrupt
   );
endinterface

// File: rtl/cmd_issue_ctrl.sv
// Host-side command issue controller: register file, issue/wait FSM toward the CMD block,
// latched response and maskable interrupt status.
module cmd_issue_ctrl #(
   parameter int unsigned ISSUE_TIMEOUT = 64
) (
   input logic        CLK_host,
   input logic        reset,
   cmd_issue_ctrl_if.slave bus
);
   localparam int unsigned CntW = $clog2(ISSUE_TIMEOUT) + 1;
   localparam logic [CntW-1:0] CntMax = CntW'(ISSUE_TIMEOUT - 1);
   // STATUS bit 2 (inhibit) is derived from state, never stored or maskable
   localparam logic [4:0] W1cMask = 5'b11011;

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e            r_state;
   logic [CntW-1:0]   r_cnt;
   logic [31:0]       r_arg;
   logic [31:0]       r_resp;
   logic [4:0]        r_status;
   logic [4:0]        r_int_en;
   logic              r_new_cmd;
   logic [31:0]       r_cmd_arg;
   logic [5:0]        r_cmd_index;
   logic              r_interrupt;

   logic              w_wr_arg;
   logic              w_wr_cmd;
   logic              w_wr_status;
   logic              w_wr_int_en;
   logic              w_active;
   logic              w_done;
   logic              w_abort;
   logic [4:0]        w_set;
   logic [4:0]        w_clr;

   always_comb begin
      w_wr_arg    = bus.reg_wr_en && (bus.reg_addr == 3'd0);
      w_wr_cmd    = bus.reg_wr_en && (bus.reg_addr == 3'd1);
      w_wr_status = bus.reg_wr_en && (bus.reg_addr == 3'd3);
      w_wr_int_en = bus.reg_wr_en && (bus.reg_addr == 3'd4);
      w_active    = (r_state != StIdle);
      w_done      = w_active && (bus.cmd_complete || bus.timeout_error);
      w_abort     = (r_state == StIssue) && !w_done && !bus.cmd_busy && (r_cnt == CntMax);
      w_set       = '0;
      w_set[0]    = w_active && bus.cmd_complete;
      w_set[1]    = (w_active && bus.timeout_error) || w_abort;
      w_set[3]    = w_wr_cmd && w_active;
      w_set[4]    = w_abort;
      w_clr       = w_wr_status ? (bus.reg_wdata[4:0] & W1cMask) : 5'b0;
   end

   always_ff @(posedge CLK_host or negedge reset) begin
      if (!reset) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_arg       <= '0;
         r_resp      <= '0;
         r_status    <= '0;
         r_int_en    <= '0;
         r_new_cmd   <= 1'b0;
         r_cmd_arg   <= '0;
         r_cmd_index <= '0;
         r_interrupt <= 1'b0;
      end else begin
         if (w_wr_arg)    r_arg    <= bus.reg_wdata;
         if (w_wr_int_en) r_int_en <= bus.reg_wdata[4:0];
         // Hardware set is ORed in after the clear so a coincident set wins
         r_status    <= (r_status & ~w_clr) | w_set;
         r_interrupt <= |(r_status & r_int_en & W1cMask);
         if (w_active && bus.cmd_complete) r_resp <= bus.response_status;

         case (r_state)
            StIdle: begin
               if (w_wr_cmd) begin
                  r_cmd_index <= bus.reg_wdata[5:0];
                  r_cmd_arg   <= r_arg;
                  r_new_cmd   <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= StIssue;
               end
            end
            StIssue: begin
               if (w_done || w_abort) begin
                  r_new_cmd <= 1'b0;
                  r_state   <= StIdle;
               end else if (bus.cmd_busy) begin
                  r_new_cmd <= 1'b0;
                  r_state   <= StWait;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            StWait: begin
               if (w_done) r_state <= StIdle;
            end
            default: begin
               r_new_cmd <= 1'b0;
               r_state   <= StIdle;
            end
         endcase
      end
   end

   always_comb begin
      bus.reg_rdata = '0;
      case (bus.reg_addr)
         3'd0:    bus.reg_rdata = r_arg;
         3'd1:    bus.reg_rdata = {26'd0, r_cmd_index};
         3'd2:    bus.reg_rdata = r_resp;
         3'd3:    bus.reg_rdata = {27'd0, r_status[4:3], w_active, r_status[1:0]};
         3'd4:    bus.reg_rdata = {27'd0, r_int_en};
         default: bus.reg_rdata = '0;
      endcase
   end

   assign bus.new_cmd   = r_new_cmd;
   assign bus.cmd_arg   = r_cmd_arg;
   assign bus.cmd_index = r_cmd_index;
   assign bus.interrupt = r_interrupt;
endmodule

// File: tb/tb_cmd_issue_ctrl.sv
// Directed self-checking bench for cmd_issue_ctrl with hand-computed expectations.
`timescale 1ns/1ps
module tb_cmd_issue_ctrl;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   hi;
   logic [31:0] rd;

   cmd_issue_ctrl_if bus ();

   cmd_issue_ctrl #(.ISSUE_TIMEOUT(64)) dut (
      .CLK_host (clk),
      .reset    (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
      bus.reg_wr_en = 1'b1;
      bus.reg_addr  = a;
      bus.reg_wdata = d;
      tick();
      bus.reg_wr_en = 1'b0;
   endtask

   task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
      bus.reg_addr = a;
      #1;
      d = bus.reg_rdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      bus.reg_wr_en = 1'b0;
      bus.reg_addr = 3'd0;
      bus.reg_wdata = '0;
      bus.cmd_busy = 1'b0;
      bus.cmd_complete = 1'b0;
      bus.timeout_error = 1'b0;
      bus.response_status = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      check("rst_new_cmd", {31'd0, bus.new_cmd}, 32'd0);
      check("rst_interrupt", {31'd0, bus.interrupt}, 32'd0);
      check("rst_cmd_index", {26'd0, bus.cmd_index}, 32'd0);
      reg_read(3'd3, rd); check("rst_status", rd, 32'h0);
      reg_read(3'd2, rd); check("rst_resp", rd, 32'h0);

      // Basic issue: busy sampled on the third edge after the CMD write
      reg_write(3'd0, 32'hDEADBEEF);
      reg_write(3'd1, 32'h0000_0011);
      check("t1_new_cmd", {31'd0, bus.new_cmd}, 32'd1);
      check("t1_cmd_index", {26'd0, bus.cmd_index}, 32'h11);
      check("t1_cmd_arg", bus.cmd_arg, 32'hDEADBEEF);
      reg_read(3'd3, rd); check("t1_inhibit", rd, 32'h04);
      hi = 0;
      for (int i = 0; i < 3; i++) begin
         if (bus.new_cmd) hi++;
         if (i == 2) bus.cmd_busy = 1'b1;
         tick();
      end
      bus.cmd_busy = 1'b0;
      check("t1_new_cmd_drop", {31'd0, bus.new_cmd}, 32'd0);
      check("t1_new_cmd_cycles", hi, 32'd3);
      tick();
      bus.cmd_complete = 1'b1;
      bus.response_status = 32'h0000_0900;
      tick();
      bus.cmd_complete = 1'b0;
      reg_read(3'd2, rd); check("t1_resp", rd, 32'h900);
      reg_read(3'd3, rd); check("t1_status", rd, 32'h01);

      // Interrupt latency and W1C clear
      reg_write(3'd3, 32'h1F);
      reg_write(3'd4, 32'h01);
      reg_write(3'd1, 32'h05);
      bus.cmd_busy = 1'b1;
      tick();
      bus.cmd_busy = 1'b0;
      bus.cmd_complete = 1'b1;
      bus.response_status = 32'h0000_1234;
      tick();
      bus.cmd_complete = 1'b0;
      check("t2_irq_edge_k", {31'd0, bus.interrupt}, 32'd0);
      tick();
      check("t2_irq_edge_k1", {31'd0, bus.interrupt}, 32'd1);
      reg_write(3'd3, 32'h01);
      reg_read(3'd3, rd); check("t2_status_clr", rd, 32'h0);
      tick();
      check("t2_irq_clr", {31'd0, bus.interrupt}, 32'd0);

      // Issue timeout with busy never asserted
      reg_write(3'd1, 32'h22);
      hi = 0;
      for (int i = 0; i < 100; i++) begin
         if (!bus.new_cmd) break;
         hi++;
         tick();
      end
      check("t3_new_cmd_cycles", hi, 32'd64);
      reg_read(3'd3, rd); check("t3_status", rd, 32'h12);

      // Dropped CMD write and ARG write while waiting
      reg_write(3'd3, 32'h1F);
      reg_write(3'd0, 32'h1111_2222);
      reg_write(3'd1, 32'h2A);
      bus.cmd_busy = 1'b1;
      tick();
      bus.cmd_busy = 1'b0;
      reg_write(3'd1, 32'h3F);
      reg_read(3'd3, rd); check("t4_dropped", rd, 32'h0C);
      check("t4_cmd_index", {26'd0, bus.cmd_index}, 32'h2A);
      reg_read(3'd1, rd); check("t4_cmd_rd", rd, 32'h2A);
      reg_write(3'd0, 32'h3333_4444);
      check("t4_cmd_arg", bus.cmd_arg, 32'h1111_2222);
      reg_read(3'd0, rd); check("t4_arg_rd", rd, 32'h3333_4444);

      // complete + timeout_error together with a W1C of bit 0
      reg_write(3'd3, 32'h08);
      bus.cmd_complete = 1'b1;
      bus.timeout_error = 1'b1;
      bus.response_status = 32'hCAFE_0001;
      bus.reg_wr_en = 1'b1;
      bus.reg_addr = 3'd3;
      bus.reg_wdata = 32'h01;
      tick();
      bus.reg_wr_en = 1'b0;
      bus.cmd_complete = 1'b0;
      bus.timeout_error = 1'b0;
      reg_read(3'd3, rd); check("t5_status", rd, 32'h03);
      reg_read(3'd2, rd); check("t5_resp", rd, 32'hCAFE_0001);

      // Asynchronous reset in WAIT
      reg_write(3'd3, 32'h1F);
      reg_write(3'd1, 32'h07);
      bus.cmd_busy = 1'b1;
      tick();
      bus.cmd_busy = 1'b0;
      reg_write(3'd1, 32'h15);
      reg_read(3'd3, rd); check("t6_pre_status", rd, 32'h0C);
      rst_n = 1'b0;
      #1;
      check("t6_new_cmd", {31'd0, bus.new_cmd}, 32'd0);
      check("t6_cmd_index", {26'd0, bus.cmd_index}, 32'd0);
      check("t6_cmd_arg", bus.cmd_arg, 32'd0);
      reg_read(3'd3, rd); check("t6_status", rd, 32'h0);
      reg_read(3'd2, rd); check("t6_resp", rd, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // Reset asserted during ISSUE drops new_cmd at once
      reg_write(3'd1, 32'h09);
      check("t6_reissue", {31'd0, bus.new_cmd}, 32'd1);
      check("t6_reissue_idx", {26'd0, bus.cmd_index}, 32'h09);
      check("t6_reissue_arg", bus.cmd_arg, 32'd0);
      rst_n = 1'b0;
      #1;
      check("t6_issue_rst", {31'd0, bus.new_cmd}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      reg_write(3'd1, 32'h0B);
      bus.cmd_busy = 1'b1;
      tick();
      bus.cmd_busy = 1'b0;
      bus.cmd_complete = 1'b1;
      bus.response_status = 32'h55;
      tick();
      bus.cmd_complete = 1'b0;
      reg_read(3'd3, rd); check("t6_post_status", rd, 32'h01);
      reg_read(3'd2, rd); check("t6_post_resp", rd, 32'h55);

      // INT_EN width and unmapped address
      reg_write(3'd4, 32'hFFFF_FFFF);
      reg_read(3'd4, rd); check("int_en_rd", rd, 32'h1F);
      reg_read(3'd5, rd); check("addr5_rd", rd, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/cmd_issue_ctrl.md
# cmd_issue_ctrl

Host-side command issue controller sitting directly upstream of the CMD block, in the CLK_host domain. It exposes a small register interface: argument, command trigger, response, status and interrupt enable. It turns a CMD-register write into a held `new_cmd` request with stable `cmd_arg`/`cmd_index`, then tracks the transaction until `cmd_complete` or `timeout_error`. It latches `response_status` and raises maskable interrupt status bits.

## Interface
Parameters:
- ISSUE_TIMEOUT, 64: max CLK_host cycles `new_cmd` is held waiting for `cmd_busy` before aborting.

Ports:
- CLK_host  in  1  host clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- reg_wr_en  in  1  register write strobe, one cycle per write.
- reg_addr  in  3  register select: 0 ARG, 1 CMD, 2 RESP, 3 STATUS, 4 INT_EN.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  combinational read of the register at `reg_addr`; 0 for addresses 5-7.
- new_cmd  out  1  command request to CMD; registered.
- cmd_arg  out  32  argument to CMD; registered.
- cmd_index  out  6  index to CMD; registered.
- cmd_busy  in  1  from CMD.
- cmd_complete  in  1  from CMD.
- timeout_error  in  1  from CMD.
- response_status  in  32  from CMD; valid while `cmd_complete`=1.
- interrupt  out  1  OR of enabled status bits; registered.

## Operation
Registers:
- ARG is R/W at any time.
- CMD write: bits[5:0] are the index.
  - A write in IDLE triggers an issue.
  - A write in any other state is ignored and sets STATUS.dropped.
  - Reads return the last accepted index.
- RESP is read-only. It is loaded from `response_status` on `cmd_complete`.
- STATUS bits:
  - [0] complete (W1C)
  - [1] timeout (W1C)
  - [2] inhibit (RO; 1 when state≠IDLE)
  - [3] dropped (W1C)
  - [4] issue_fail (W1C)
  - [31:5] read 0
- INT_EN is R/W; bits [4:0] are used and bit 2 is ignored.
- `interrupt` = |(STATUS[4:3,1:0] & INT_EN[4:3,1:0]).

State machine (IDLE, ISSUE, WAIT):
- IDLE: on an accepted CMD write, load `cmd_index` from reg_wdata[5:0] and `cmd_arg` from ARG (or from reg_wdata, if ARG is written the same cycle, so the new value is used). Then go to ISSUE.
- ISSUE: `new_cmd`=1, counter runs.
  - `cmd_busy`=1 → WAIT.
  - Counter reaches ISSUE_TIMEOUT-1 without busy → set issue_fail and timeout, go to IDLE.
- WAIT: `new_cmd`=0.
  - `cmd_complete`=1 → load RESP, set complete, go to IDLE.
  - `timeout_error`=1 → set timeout, go to IDLE.
  - Both in the same cycle → both bits set, RESP loaded.
  - `cmd_complete` or `timeout_error` seen in ISSUE is handled the same way and takes priority over the busy check.
- `cmd_arg`/`cmd_index` stay constant from issue until the next accepted issue. ARG writes mid-command do not disturb them.

Boundary rules:
- A W1C write in the same cycle as a hardware set of the same bit: the set wins.
- Counter width is $clog2(ISSUE_TIMEOUT)+1. The counter clears on entry to ISSUE.
- reset=0 at any time, including mid-command:
  - State goes to IDLE immediately.
  - All registers, `new_cmd`, `cmd_arg`, `cmd_index`, `interrupt` and the counter clear to 0.

## Timing
- Reset values are 0 on every output and register. STATUS.inhibit reads 0.
- An accepted CMD write at edge N gives `new_cmd`=1 and valid `cmd_arg`/`cmd_index` after edge N; inhibit=1 from the same point.
- `cmd_busy` sampled 1 at edge M gives `new_cmd`=0 after edge M. `new_cmd` is high for at least 1 cycle.
- `cmd_complete` sampled at edge K:
  - RESP, STATUS.complete and IDLE are visible after edge K.
  - `interrupt` rises after edge K+1.
- Issue-timeout abort: with no busy, `new_cmd` is high for exactly ISSUE_TIMEOUT cycles.
- Back-to-back: a CMD write is accepted on the first cycle in which the state is IDLE.

## Test plan
- Reset, then write ARG=0xDEADBEEF and CMD=0x11; CMD raises busy 3 cycles later and complete with response 0x00000900 → `new_cmd` high for 3 cycles, `cmd_index`=0x11, `cmd_arg`=0xDEADBEEF, RESP=0x900, STATUS=0x01.
- INT_EN=0x01, then a completed command → `interrupt`=1; write STATUS=0x01 → STATUS=0, `interrupt`=0 next cycle.
- `cmd_busy` never asserts, ISSUE_TIMEOUT=64 → `new_cmd` high for exactly 64 cycles, STATUS=0x12, state IDLE.
- CMD write while WAIT → STATUS.dropped=1, `cmd_index` unchanged; ARG write mid-command leaves `cmd_arg` unchanged.
- `timeout_error` and `cmd_complete` in the same cycle, plus a W1C of bit0 the same cycle → STATUS=0x03, RESP loaded.
- Assert reset in WAIT → `new_cmd`, STATUS and RESP are 0 immediately; after release a new CMD write issues normally.
